// File: rtl/mod_state_counter_if.sv
// Control/status bundle for mod_state_counter.
// master: sequencer that drives the counter; slave: the counter itself.
interface mod_state_counter_if #(
    parameter int WIDTH = 4
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             dir;
    logic [WIDTH-1:0] state_out;
    logic             tc;
    logic             err;

    modport master (
        output clear, load, load_val, en, dir,
        input  state_out, tc, err
    );

    modport slave (
        input  clear, load, load_val, en, dir,
        output state_out, tc, err
    );
endinterface

// File: rtl/mod_state_counter.sv
// mod_state_counter: configurable Moore state counter (0..MODULUS-1), up/down,
// synchronous clear/load, wrap or saturate, terminal count, sticky illegal-load flag.
// Optional feature macro: GRAY_OUT_EN (Gray-coded state_out; internals stay binary).
module mod_state_counter #(
    parameter int WIDTH       = 4,
    parameter int MODULUS     = 10,
    parameter int RESET_STATE = MODULUS - 1,
    parameter int SATURATE    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    mod_state_counter_if.slave   bus
);
    localparam int               W1       = WIDTH + 1;
    // One extra bit so MODULUS = 2**WIDTH is representable for compares.
    localparam logic [WIDTH:0]   MOD_EXT  = W1'(MODULUS);
    localparam logic [WIDTH:0]   LAST_EXT = W1'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(RESET_STATE);

    logic [WIDTH-1:0] r_state;
    logic             r_err;
    logic [WIDTH:0]   w_state_ext;
    logic             w_state_bad;
    logic             w_load_ok;
    logic             w_at_top;
    logic             w_at_bot;
    logic [WIDTH-1:0] w_step;

    // Next counted state for a legal current state, handling wrap/saturate at both ends.
    function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] s, input logic up);
        logic [WIDTH:0] s_ext;
        logic [WIDTH:0] nxt;
        s_ext = {1'b0, s};
        if (up) begin
            nxt = s_ext + W1'(1);
            if (nxt >= MOD_EXT) begin
                nxt = (SATURATE != 0) ? s_ext : '0;
            end
        end else begin
            if (s_ext == '0) begin
                nxt = (SATURATE != 0) ? s_ext : LAST_EXT;
            end else begin
                nxt = s_ext - W1'(1);
            end
        end
        return nxt[WIDTH-1:0];
    endfunction

    assign w_state_ext = {1'b0, r_state};
    assign w_state_bad = (w_state_ext >= MOD_EXT);
    assign w_load_ok   = ({1'b0, bus.load_val} < MOD_EXT);
    assign w_at_top    = (w_state_ext == LAST_EXT);
    assign w_at_bot    = (r_state == '0);
    assign w_step      = f_step(r_state, bus.dir);

    // State and sticky error register: async reset, then clear > load > en > hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RST_VAL;
            r_err   <= 1'b0;
        end else if (bus.clear) begin
            r_state <= '0;
            r_err   <= 1'b0;
        end else if (bus.load) begin
            if (w_load_ok) begin
                r_state <= bus.load_val;
            end else begin
                r_state <= '0;
                r_err   <= 1'b1;
            end
        end else if (bus.en) begin
            // An out-of-range state can only come from an upset; recover to 0.
            r_state <= w_state_bad ? '0 : w_step;
        end
    end

    assign bus.tc  = bus.en & ~bus.clear & ~bus.load &
                     ((bus.dir & w_at_top) | (~bus.dir & w_at_bot));
    assign bus.err = r_err;

`ifdef GRAY_OUT_EN
    assign bus.state_out = r_state ^ (r_state >> 1);
`else
    assign bus.state_out = r_state;
`endif

endmodule

// File: tb/tb_mod_state_counter.sv
// Directed bench for mod_state_counter: default, saturating and 2**WIDTH instances.
module tb_mod_state_counter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mod_state_counter_if #(.WIDTH(4)) bus_a ();
    mod_state_counter_if #(.WIDTH(4)) bus_b ();
    mod_state_counter_if #(.WIDTH(4)) bus_c ();

    mod_state_counter #(.WIDTH(4), .MODULUS(10), .RESET_STATE(9), .SATURATE(0)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    mod_state_counter #(.WIDTH(4), .MODULUS(10), .RESET_STATE(9), .SATURATE(1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));
    mod_state_counter #(.WIDTH(4), .MODULUS(16), .RESET_STATE(15), .SATURATE(0)) dut_c (
        .clk(clk), .reset(reset), .bus(bus_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gray codes of 0..15, written out by hand.
    logic [3:0] gray_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected external view of dut_c for binary state s.
    function automatic logic [3:0] c_out(input int s);
`ifdef GRAY_OUT_EN
        return gray_tbl[s];
`else
        return 4'(s);
`endif
    endfunction

    initial begin
        int exp_s;
        logic [3:0] prev_c;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bus_a.clear = 0; bus_a.load = 0; bus_a.load_val = 0; bus_a.en = 0; bus_a.dir = 0;
        bus_b.clear = 0; bus_b.load = 0; bus_b.load_val = 0; bus_b.en = 0; bus_b.dir = 0;
        bus_c.clear = 0; bus_c.load = 0; bus_c.load_val = 0; bus_c.en = 0; bus_c.dir = 0;

        // Reset held low for two edges
        step();
        step();
        chk("rst_state_a", bus_a.state_out, 9);
        chk("rst_err_a", bus_a.err, 0);
        chk("rst_tc_a", bus_a.tc, 0);
        chk("rst_state_c", bus_c.state_out, c_out(15));
        bus_a.en = 1; bus_a.dir = 1;
        #1;
        chk("rst_tc_en_a", bus_a.tc, 1);
        chk("rst_hold_a", bus_a.state_out, 9);

        // Release and count up through the wrap
        reset = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            exp_s = (k - 1) % 10;
            chk("up_state", bus_a.state_out, exp_s);
            chk("up_tc", bus_a.tc, (exp_s == 9) ? 1 : 0);
        end

        // Down wrap from a loaded 2
        bus_a.load = 1; bus_a.load_val = 2; bus_a.dir = 0;
        step();
        chk("ld2_state", bus_a.state_out, 2);
        bus_a.load = 0;
        #1;
        chk("dn_tc_2", bus_a.tc, 0);
        step(); chk("dn_state_1", bus_a.state_out, 1); chk("dn_tc_1", bus_a.tc, 0);
        step(); chk("dn_state_0", bus_a.state_out, 0); chk("dn_tc_0", bus_a.tc, 1);
        bus_a.load = 1; bus_a.load_val = 0;
        #1;
        chk("tc_masked_load", bus_a.tc, 0);
        bus_a.load = 0;
        #1;
        step(); chk("dn_state_9", bus_a.state_out, 9); chk("dn_tc_9", bus_a.tc, 0);
        step(); chk("dn_state_8", bus_a.state_out, 8);

        // Priority: clear over load over en
        bus_a.clear = 1; bus_a.load = 1; bus_a.load_val = 5; bus_a.en = 1;
        #1;
        chk("tc_masked_clear", bus_a.tc, 0);
        step();
        chk("prio_state", bus_a.state_out, 0);
        chk("prio_err", bus_a.err, 0);
        bus_a.clear = 0; bus_a.load = 1; bus_a.load_val = 12; bus_a.en = 1; bus_a.dir = 1;
        #1;
        chk("err_before_edge", bus_a.err, 0);
        step();
        chk("illegal_state", bus_a.state_out, 0);
        chk("illegal_err", bus_a.err, 1);
        bus_a.load_val = 5;
        step();
        chk("legal_ld_state", bus_a.state_out, 5);
        chk("legal_ld_err", bus_a.err, 1);
        bus_a.load = 0; bus_a.en = 0;
        step();
        chk("hold_state", bus_a.state_out, 5);
        chk("hold_err", bus_a.err, 1);
        bus_a.clear = 1;
        step();
        chk("clr_state", bus_a.state_out, 0);
        chk("clr_err", bus_a.err, 0);
        bus_a.clear = 0;

        // Saturating instance
        bus_b.load = 1; bus_b.load_val = 8; bus_b.en = 1; bus_b.dir = 1;
        step();
        chk("sat_ld8", bus_b.state_out, 8);
        bus_b.load = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("sat_top_state", bus_b.state_out, 9);
            chk("sat_top_tc", bus_b.tc, 1);
        end
        bus_b.dir = 0;
        #1;
        chk("sat_dn_tc", bus_b.tc, 0);
        step();
        chk("sat_dn_state", bus_b.state_out, 8);
        bus_b.load = 1; bus_b.load_val = 1;
        step();
        bus_b.load = 0;
        step(); chk("sat_bot_0", bus_b.state_out, 0); chk("sat_bot_tc", bus_b.tc, 1);
        step(); chk("sat_bot_hold", bus_b.state_out, 0);

        // Asynchronous reset between edges, mid-count
        bus_a.load = 1; bus_a.load_val = 2; bus_a.en = 1; bus_a.dir = 1;
        step();
        bus_a.load = 0;
        step();
        step();
        chk("pre_arst_state", bus_a.state_out, 4);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_state", bus_a.state_out, 9);
        chk("arst_err", bus_a.err, 0);
        step();
        chk("arst_held", bus_a.state_out, 9);
        reset = 1'b1;
        step();
        chk("resume_0", bus_a.state_out, 0);
        step();
        chk("resume_1", bus_a.state_out, 1);
        bus_a.en = 0;

        // MODULUS = 2**WIDTH instance: full cycle including the 15 -> 0 wrap
        bus_c.clear = 1;
        step();
        bus_c.clear = 0; bus_c.en = 1; bus_c.dir = 1;
        chk("c_clr", bus_c.state_out, c_out(0));
        prev_c = bus_c.state_out;
        for (int k = 1; k <= 16; k++) begin
            step();
            exp_s = k % 16;
            chk("c_state", bus_c.state_out, c_out(exp_s));
            chk("c_tc", bus_c.tc, (exp_s == 15) ? 1 : 0);
`ifdef GRAY_OUT_EN
            chk("c_onebit", $countones(bus_c.state_out ^ prev_c), 1);
`endif
            prev_c = bus_c.state_out;
        end
        bus_c.dir = 0;
        step();
        chk("c_dn_wrap", bus_c.state_out, c_out(15));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
